// File: rtl/vga_if.sv
// vga_if: frame-memory read port and display pins between the scanout and the rest of the system
interface vga_if #(
  parameter int COLOR_W = 12
);
  logic [COLOR_W-1:0] i_color;
  logic [7:0]         o_pxlX;
  logic [7:0]         o_pxlY;
  logic               o_hsync;
  logic               o_vsync;
  logic               o_de;
  logic [COLOR_W-1:0] o_rgb;
  logic               o_vblank;
  logic               o_frame_start;
  modport master (
    input  i_color,
    output o_pxlX, o_pxlY, o_hsync, o_vsync, o_de, o_rgb, o_vblank, o_frame_start
  );
  modport slave (
    output i_color,
    input  o_pxlX, o_pxlY, o_hsync, o_vsync, o_de, o_rgb, o_vblank, o_frame_start
  );
endinterface

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 timing generator that reads the frame memory and aligns sync/de with its latency
module vga_scanout #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 2,
  parameter int READ_LAT    = 1,
  parameter int COLOR_W     = 12,
  parameter bit SYNC_POL    = 1'b0
) (
  input logic  i_clk,
  input logic  i_reset,
  vga_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0]      h_cnt_q, h_cnt_d;
  logic [VW-1:0]      v_cnt_q, v_cnt_d;
  logic               active, hs_raw, vs_raw;
  logic [2:0]         dly;
  logic               de_q, hs_q, vs_q, vblank_q, fs_q;
  logic [COLOR_W-1:0] rgb_q;

  // raster position advance and raw timing decoded from the current position
  always_comb begin
    h_cnt_d = h_cnt_q == H_LAST ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = h_cnt_q != H_LAST ? v_cnt_q : v_cnt_q == V_LAST ? '0 : v_cnt_q + 1'b1;
    active  = h_cnt_q < H_ACT && v_cnt_q < V_ACT;
    hs_raw  = h_cnt_q >= HS_BEG && h_cnt_q < HS_END;
    vs_raw  = v_cnt_q >= VS_BEG && v_cnt_q < VS_END;
  end

  assign vga.o_pxlX = active ? 8'(h_cnt_q >> SCALE_SHIFT) : '0;
  assign vga.o_pxlY = active ? 8'(v_cnt_q >> SCALE_SHIFT) : '0;

  if (READ_LAT == 0) begin : g_nolat
    assign dly = {active, hs_raw, vs_raw};
  end else begin : g_lat
    logic [2:0] sr_q [READ_LAT];
    // delay raw timing so it meets the colour the memory returns for the same position
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        for (int k = 0; k < READ_LAT; k++) sr_q[k] <= '0;
      end else begin
        sr_q[0] <= {active, hs_raw, vs_raw};
        for (int k = 1; k < READ_LAT; k++) sr_q[k] <= sr_q[k-1];
      end
    end
    assign dly = sr_q[READ_LAT-1];
  end

  // counters, glitch-free pin registers and frame status
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      de_q     <= 1'b0;
      rgb_q    <= '0;
      hs_q     <= ~SYNC_POL;
      vs_q     <= ~SYNC_POL;
      vblank_q <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      de_q     <= dly[2];
      rgb_q    <= dly[2] ? vga.i_color : '0;
      hs_q     <= dly[1] ? SYNC_POL : ~SYNC_POL;
      vs_q     <= dly[0] ? SYNC_POL : ~SYNC_POL;
      vblank_q <= v_cnt_q >= V_ACT;
      fs_q     <= h_cnt_q == '0 && v_cnt_q == '0;
    end
  end

  assign vga.o_de          = de_q;
  assign vga.o_rgb         = rgb_q;
  assign vga.o_hsync       = hs_q;
  assign vga.o_vsync       = vs_q;
  assign vga.o_vblank      = vblank_q;
  assign vga.o_frame_start = fs_q;
endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Display-side reader for the double-buffered VGA frame memory: generates 640x480@60 timing, drives pixel coordinates (o_pxlX/o_pxlY) into the frame memory and consumes the returned colour.
- Aligns hsync/vsync/data-enable with the memory read latency.
- Exports vblank and frame-start status so the CPU can time buffer swaps.
- Runs entirely in the pixel clock domain (25 MHz nominal).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SCALE_SHIFT, 2, log2 of the screen-to-framebuffer scale (640x480 -> 160x120)
- READ_LAT, 1, frame-memory read latency in clocks, from coordinate valid to colour valid; range 0..4
- COLOR_W, 12, colour width (4:4:4 RGB)
- SYNC_POL, 0, sync active level (0 = active-low)

Ports:
- i_clk  input  1  pixel clock; the only clock
- i_reset  input  1  synchronous reset, active-high
- i_color  input  COLOR_W  colour returned by the frame memory for the coordinates issued READ_LAT clocks earlier
- o_pxlX  output  8  framebuffer column = h_cnt >> SCALE_SHIFT during active video, else 0
- o_pxlY  output  8  framebuffer row = v_cnt >> SCALE_SHIFT during active video, else 0
- o_hsync  output  1  horizontal sync, level per SYNC_POL
- o_vsync  output  1  vertical sync, level per SYNC_POL
- o_de  output  1  data enable (visible pixel on o_rgb)
- o_rgb  output  COLOR_W  pixel colour; 0 when o_de is low
- o_vblank  output  1  high while v_cnt >= V_ACTIVE
- o_frame_start  output  1  one-clock pulse at the start of each frame

Behaviour:
- Counters:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (800); V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP (525).
  - h_cnt increments every clock and wraps from H_TOTAL-1 to 0.
  - v_cnt increments when h_cnt wraps, and wraps from V_TOTAL-1 to 0 when both counters are at their maximum.
- Raw timing, derived from the counters:
  - active = h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
  - hs_raw is asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw is asserted for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), for entire lines.
- Coordinates:
  - o_pxlX/o_pxlY are combinational from the registered counters, so they are valid in the same clock as the counter value.
  - They are forced to 0 outside active video.
- Alignment pipeline:
  - active, hs_raw and vs_raw pass through a READ_LAT-deep shift register, then one output register.
  - The output register captures o_de, o_hsync, o_vsync, and o_rgb = de_delayed ? i_color : 0.
  - Total latency from counter value to pins is READ_LAT+1 clocks for all four signals, so o_rgb always pairs with the o_de/o_hsync/o_vsync of the same counter position.
- Status outputs (registered, 1-clock latency from the counter; not delayed by READ_LAT):
  - o_vblank = (v_cnt >= V_ACTIVE).
  - o_frame_start = (h_cnt == 0 && v_cnt == 0), high for exactly one clock per frame.
- Reset:
  - Counters go to 0 and the shift register clears.
  - o_de = 0, o_rgb = 0, o_hsync = o_vsync = ~SYNC_POL (inactive), o_vblank = 0, o_frame_start = 0.
  - Reset asserted mid-frame takes effect on the next clock edge and discards the partial frame.
  - In the first clock after release h_cnt = 0 and v_cnt = 0; o_frame_start pulses on the following clock.
- Boundaries:
  - At h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1, both counters wrap in the same clock.
  - Line 479, pixel 639 is the last visible pixel (o_pxlX = 159, o_pxlY = 119).
  - The sync outputs never glitch between registered updates.
  - i_color is ignored while de_delayed is low.
- Arithmetic:
  - Counters are 10 bits wide, sized by $clog2 of H_TOTAL and V_TOTAL.
  - The coordinate shift truncates to 8 bits; no saturation is needed because the active range maps to <=159 and <=119.

Test Plan:
- Reset, then run 2 lines -> o_hsync period 800 clocks; low for 96 clocks starting 656+READ_LAT+1 clocks after reset release (1 clock later when READ_LAT=1); o_de high for 640 consecutive clocks per line.
- Run 2 full frames -> o_vsync period 420000 clocks, low for 1600 clocks; o_frame_start exactly one pulse per 420000 clocks; o_vblank high 36000 clocks per frame.
- Memory model with latency 1 returning i_color = {o_pxlY[5:0], o_pxlX[5:0]} -> at o_de high, screen pixel (h=7, v=4) shows X=1, Y=1; screen (639,479) shows 0x{119,159 truncated}; no misalignment anywhere in a frame.
- Hold i_color = 12'hFFF constantly -> o_rgb = 0 whenever o_de = 0 (porches, sync, vblank); o_pxlX/o_pxlY = 0 outside active.
- Assert i_reset for 3 clocks at line 200, pixel 300 -> next clock o_de = 0, o_rgb = 0, syncs inactive; after release, timing restarts from (0,0) and o_frame_start pulses 1 clock after release.
- Rebuild with READ_LAT=3 and a 3-clock memory model -> o_rgb/o_de alignment holds; sync edges shift 2 clocks later than in the READ_LAT=1 run.
